bound_flasher_ctrl: RTL



---
 rtl/bound_flasher_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/bound_flasher_ctrl.sv
// Sequencing controller for the 16-lamp bound flasher: owns the state register,
// applies the decoder's behaviour code to a thermometer LED register at a prescaled rate.
module bound_flasher_ctrl #(
    parameter int unsigned STEP_DIV = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flick,
    input  logic [1:0]  led_bhv,
    output logic [2:0]  cur_st,
    output logic [15:0] led
);

    typedef enum logic [2:0] {
        ST_INITIAL  = 3'd0,
        ST_0_TO_15  = 3'd1,
        ST_15_TO_5  = 3'd2,
        ST_5_TO_10  = 3'd3,
        ST_10_TO_0  = 3'd4,
        ST_0_TO_5   = 3'd5,
        ST_5_TO_0   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ret;
    logic             step;
    logic [15:0]      led_nxt;

    assign step   = (cnt == CNT_MAX);
    assign cur_st = state;

    // Shifting a full or empty thermometer code saturates on its own.
    always_comb begin
        led_nxt = led;
        case (led_bhv)
            2'd1:    led_nxt = {led[14:0], 1'b1};
            2'd0:    led_nxt = {1'b0, led[15:1]};
            default: led_nxt = led;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INITIAL;
            led   <= '0;
            cnt   <= '0;
            ret   <= 1'b0;
        end else if (state == ST_INITIAL) begin
            cnt <= '0;
            if (flick) begin
                state <= ST_0_TO_15;
                ret   <= 1'b0;
            end
        end else begin
            cnt <= step ? '0 : cnt + CNT_W'(1);
            if (step) begin
                led <= led_nxt;
                case (state)
                    ST_0_TO_15: begin
                        if (flick && (led_nxt == 16'h003F || led_nxt == 16'h07FF)) begin
                            state <= ST_10_TO_0;
                            ret   <= 1'b1;
                        end else if (led_nxt == 16'hFFFF) begin
                            state <= ST_15_TO_5;
                        end
                    end
                    ST_15_TO_5: if (led_nxt == 16'h003F) state <= ST_5_TO_10;
                    ST_5_TO_10: if (led_nxt == 16'h07FF) state <= flick ? ST_15_TO_5 : ST_10_TO_0;
                    ST_10_TO_0: begin
                        if (led_nxt == 16'h0000) begin
                            state <= ret ? ST_0_TO_15 : ST_0_TO_5;
                            ret   <= 1'b0;
                        end
                    end
                    ST_0_TO_5:  if (led_nxt == 16'h003F) state <= ST_5_TO_0;
                    ST_5_TO_0:  if (led_nxt == 16'h0000) state <= ST_INITIAL;
                    default: begin
                        state <= ST_INITIAL;
                        led   <= '0;
                        cnt   <= '0;
                        ret   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
